crt_param_gen: RTL

- Precompute stage directly upstream of the RSA CRT decryption core.
- Takes private key factors p, q and private exponent d, and serially derives the CRT parameters:
  - dp = d mod (p-1)
  - dq = d mod (q-1)
  - qinv = q^-1 mod p
- Results feed the decryption core's exponent and recombination inputs.
- Uses one shared shift-subtract reducer plus a binary extended-GCD loop; no multipliers.

---
 rtl/crt_pkg.sv | 35 +++
 rtl/crt_param_gen_if.sv | 38 +++
 rtl/serial_mod.sv | 85 ++++++++
 rtl/crt_param_gen.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/crt_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : crt_pkg
//  Purpose : Shared types and constants for the RSA CRT parameter generator.
//            Holds the controller state encoding, the default operand width
//            and the cycle bound of the extended-GCD loop.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package crt_pkg;

    localparam int W_DEFAULT = 32;

    // The inverse loop shrinks u or v by at least one bit every two steps,
    // so 4*W cycles is a hard ceiling for any legal operand pair.
    localparam int INV_BOUND_FACTOR = 4;
    localparam int INV_MAX_DEFAULT  = INV_BOUND_FACTOR * W_DEFAULT;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHK    = 3'd1,
        RED_DP = 3'd2,
        RED_DQ = 3'd3,
        RED_Q  = 3'd4,
        INV    = 3'd5,
        FIN    = 3'd6,
        ERR    = 3'd7
    } state_t;

    function automatic int inv_bound(input int w);
        return INV_BOUND_FACTOR * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crt_param_gen_if.sv
`default_nettype none
// ============================================================================
//  Module  : crt_param_gen_if
//  Purpose : Request/result bundle of the CRT parameter generator.
//  Ports   : start, p, q, d        (requester -> generator)
//            dp, dq, qinv, busy,
//            done, err             (generator -> requester)
//            master modport = requester side, slave modport = generator side
//  Rev     : 1.0  initial release
// ============================================================================
interface crt_param_gen_if #(
    parameter int W = crt_pkg::W_DEFAULT
);
    import crt_pkg::*;

    logic         start;
    logic [W-1:0] p;
    logic [W-1:0] q;
    logic [W-1:0] d;
    logic [W-1:0] dp;
    logic [W-1:0] dq;
    logic [W-1:0] qinv;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        output start, p, q, d,
        input  dp, dq, qinv, busy, done, err
    );

    modport slave (
        input  start, p, q, d,
        output dp, dq, qinv, busy, done, err
    );

endinterface
`default_nettype wire

// File: rtl/serial_mod.sv
`default_nettype none
// ============================================================================
//  Module  : serial_mod
//  Purpose : W-cycle restoring reducer computing dividend mod divisor, one
//            dividend bit per step, MSB first.
//  Ports   : clk, rst        clock / asynchronous active-high reset
//            load            latch dividend/divisor, clear remainder
//            step            process the next dividend bit
//            dividend        value to reduce
//            divisor         modulus (non-zero)
//            result          remainder after the current step (combinational)
//            rdy             current step is the last one; result is final
//  Rev     : 1.0  initial release
// ============================================================================
module serial_mod
    import crt_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         load,
    input  wire logic         step,
    input  wire logic [W-1:0] dividend,
    input  wire logic [W-1:0] divisor,
    output logic      [W-1:0] result,
    output logic              rdy
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]     dvd_q, dvd_d;
    logic [W-1:0]     div_q, div_d;
    logic [W-1:0]     rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The stored remainder is always below the divisor, so it fits in W
    // bits; only the shifted working value needs the extra bit.
    logic [W:0]   rem_shift;
    logic [W-1:0] rem_next;

    always_comb begin
        rem_shift = {rem_q, dvd_q[W-1]};
        if (rem_shift >= {1'b0, div_q}) begin
            rem_next = W'(rem_shift - {1'b0, div_q});
        end else begin
            rem_next = rem_shift[W-1:0];
        end
        result = rem_next;
        rdy    = step && (cnt_q == CNT_W'(W - 1));
    end

    always_comb begin
        dvd_d = dvd_q;
        div_d = div_q;
        rem_d = rem_q;
        cnt_d = cnt_q;
        if (load) begin
            dvd_d = dividend;
            div_d = divisor;
            rem_d = '0;
            cnt_d = '0;
        end else if (step) begin
            dvd_d = dvd_q << 1;
            rem_d = rem_next;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_q <= '0;
            div_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
        end else begin
            dvd_q <= dvd_d;
            div_q <= div_d;
            rem_q <= rem_d;
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/crt_param_gen.sv
`default_nettype none
// ============================================================================
//  Module  : crt_param_gen
//  Purpose : Serially derives RSA CRT parameters from p, q, d:
//              dp = d mod (p-1), dq = d mod (q-1), qinv = q^-1 mod p
//            using one shared shift-subtract reducer followed by a binary
//            extended-GCD loop.
//  Ports   : clk             rising-edge clock
//            rst             asynchronous active-high reset
//            bus (slave)     start/p/q/d in; dp/dq/qinv/busy/done/err out
//  Rev     : 1.0  initial release
// ============================================================================
module crt_param_gen
    import crt_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  wire logic        clk,
    input  wire logic        rst,
    crt_param_gen_if.slave   bus
);

    localparam int INV_MAX   = inv_bound(W);
    localparam int INV_CNT_W = $clog2(INV_MAX + 1);

    state_t state_q, state_d;

    logic                 start_prev_q, start_prev_d;
    logic [W-1:0]         p_q, p_d;
    logic [W-1:0]         q_q, q_d;
    logic [W-1:0]         d_q, d_d;
    logic [W-1:0]         dp_r_q, dp_r_d;
    logic [W-1:0]         dq_r_q, dq_r_d;
    logic [W-1:0]         qinv_r_q, qinv_r_d;
    logic [W-1:0]         u_q, u_d;
    logic [W-1:0]         v_q, v_d;
    logic [W-1:0]         x1_q, x1_d;
    logic [W-1:0]         x2_q, x2_d;
    logic [INV_CNT_W-1:0] inv_cnt_q, inv_cnt_d;
    logic [W-1:0]         dp_q, dp_d;
    logic [W-1:0]         dq_q, dq_d;
    logic [W-1:0]         qinv_q, qinv_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 sm_load;
    logic                 sm_step;
    logic [W-1:0]         sm_dividend;
    logic [W-1:0]         sm_divisor;
    logic [W-1:0]         sm_result;
    logic                 sm_rdy;

    // x/2 mod m for odd m: an odd x is made even by adding m first.
    function automatic logic [W-1:0] half_mod(input logic [W-1:0] x,
                                              input logic [W-1:0] m);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, m};
        if (x[0]) begin
            return W'(s >> 1);
        end
        return x >> 1;
    endfunction

    // (a - b) mod m for a, b already in [0, m-1].
    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [W-1:0] m);
        if (a >= b) begin
            return a - b;
        end
        return W'({1'b0, a} + {1'b0, m} - {1'b0, b});
    endfunction

    serial_mod #(
        .W (W)
    ) u_serial_mod (
        .clk      (clk),
        .rst      (rst),
        .load     (sm_load),
        .step     (sm_step),
        .dividend (sm_dividend),
        .divisor  (sm_divisor),
        .result   (sm_result),
        .rdy      (sm_rdy)
    );

    always_comb begin
        state_d      = state_q;
        start_prev_d = bus.start;
        p_d          = p_q;
        q_d          = q_q;
        d_d          = d_q;
        dp_r_d       = dp_r_q;
        dq_r_d       = dq_r_q;
        qinv_r_d     = qinv_r_q;
        u_d          = u_q;
        v_d          = v_q;
        x1_d         = x1_q;
        x2_d         = x2_q;
        inv_cnt_d    = inv_cnt_q;
        dp_d         = dp_q;
        dq_d         = dq_q;
        qinv_d       = qinv_q;
        done_d       = 1'b0;
        err_d        = err_q;
        sm_load      = 1'b0;
        sm_step      = 1'b0;
        sm_dividend  = d_q;
        sm_divisor   = p_q - W'(1);

        case (state_q)
            IDLE: begin
                if (bus.start && !start_prev_q) begin
                    p_d     = bus.p;
                    q_d     = bus.q;
                    d_d     = bus.d;
                    state_d = CHK;
                end
            end

            CHK: begin
                if (!p_q[0] || (p_q < W'(3)) || (q_q < W'(3))) begin
                    state_d = ERR;
                end else begin
                    sm_load     = 1'b1;
                    sm_dividend = d_q;
                    sm_divisor  = p_q - W'(1);
                    state_d     = RED_DP;
                end
            end

            // Each reduction reloads the reducer on its final step so the
            // next one starts on the following clock with no gap cycle.
            RED_DP: begin
                sm_step = 1'b1;
                if (sm_rdy) begin
                    dp_r_d      = sm_result;
                    sm_load     = 1'b1;
                    sm_dividend = d_q;
                    sm_divisor  = q_q - W'(1);
                    state_d     = RED_DQ;
                end
            end

            RED_DQ: begin
                sm_step = 1'b1;
                if (sm_rdy) begin
                    dq_r_d      = sm_result;
                    sm_load     = 1'b1;
                    sm_dividend = q_q;
                    sm_divisor  = p_q;
                    state_d     = RED_Q;
                end
            end

            RED_Q: begin
                sm_step = 1'b1;
                if (sm_rdy) begin
                    u_d       = sm_result;
                    v_d       = p_q;
                    x1_d      = W'(1);
                    x2_d      = '0;
                    inv_cnt_d = '0;
                    state_d   = INV;
                end
            end

            // Invariants: x1*q == u and x2*q == v (mod p).
            INV: begin
                inv_cnt_d = inv_cnt_q + INV_CNT_W'(1);
                if (u_q == W'(1)) begin
                    qinv_r_d = x1_q;
                    state_d  = FIN;
                end else if (v_q == W'(1)) begin
                    qinv_r_d = x2_q;
                    state_d  = FIN;
                end else if ((u_q == '0) || (v_q == '0)) begin
                    state_d  = ERR;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = half_mod(x1_q, p_q);
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = half_mod(x2_q, p_q);
                end else if (u_q >= v_q) begin
                    u_d  = u_q - v_q;
                    x1_d = sub_mod(x1_q, x2_q, p_q);
                end else begin
                    v_d  = v_q - u_q;
                    x2_d = sub_mod(x2_q, x1_q, p_q);
                end
            end

            FIN: begin
                dp_d    = dp_r_q;
                dq_d    = dq_r_q;
                qinv_d  = qinv_r_q;
                done_d  = 1'b1;
                err_d   = 1'b0;
                state_d = IDLE;
            end

            ERR: begin
                dp_d    = '0;
                dq_d    = '0;
                qinv_d  = '0;
                done_d  = 1'b1;
                err_d   = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            start_prev_q <= 1'b0;
            p_q          <= '0;
            q_q          <= '0;
            d_q          <= '0;
            dp_r_q       <= '0;
            dq_r_q       <= '0;
            qinv_r_q     <= '0;
            u_q          <= '0;
            v_q          <= '0;
            x1_q         <= '0;
            x2_q         <= '0;
            inv_cnt_q    <= '0;
            dp_q         <= '0;
            dq_q         <= '0;
            qinv_q       <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            p_q          <= p_d;
            q_q          <= q_d;
            d_q          <= d_d;
            dp_r_q       <= dp_r_d;
            dq_r_q       <= dq_r_d;
            qinv_r_q     <= qinv_r_d;
            u_q          <= u_d;
            v_q          <= v_d;
            x1_q         <= x1_d;
            x2_q         <= x2_d;
            inv_cnt_q    <= inv_cnt_d;
            dp_q         <= dp_d;
            dq_q         <= dq_d;
            qinv_q       <= qinv_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.dp   = dp_q;
    assign bus.dq   = dq_q;
    assign bus.qinv = qinv_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.busy = (state_q != IDLE);

    // Running past the bound means the inverse loop itself is broken.
    a_inv_bound: assert property (@(posedge clk) disable iff (rst)
        (state_q == INV) |-> (inv_cnt_q < INV_CNT_W'(INV_MAX)));

endmodule
`default_nettype wire
